// File: rtl/wait_event_mc_if.sv
// Bus between the scenario sequencer and the wait-event engine.
// The sequencer drives start/abort and the wait parameters; the engine
// returns busy, the completion/timeout pulses and the elapsed count.
interface wait_event_mc_if #(
    parameter int WAIT_SIZE  = 8,
    parameter int WAIT_WIDTH = 1,
    parameter int TIMEOUT_W  = 32,
    parameter int OCC_W      = 8,
    parameter int SEL_W      = (WAIT_SIZE > 1) ? $clog2(WAIT_SIZE) : 1
);
    logic                            en_wait_event;
    logic                            abort;
    logic [SEL_W-1:0]                wait_sel;
    logic [1:0]                      mode;
    logic [WAIT_WIDTH-1:0]           mask;
    logic [WAIT_WIDTH-1:0]           value;
    logic [OCC_W-1:0]                occ_nb;
    logic [TIMEOUT_W-1:0]            max_timeout;
    logic [WAIT_SIZE*WAIT_WIDTH-1:0] wait_bank;
    logic                            busy;
    logic                            wait_done;
    logic                            timeout;
    logic [TIMEOUT_W-1:0]            elapsed;

    modport master (
        output en_wait_event, abort, wait_sel, mode, mask, value,
               occ_nb, max_timeout, wait_bank,
        input  busy, wait_done, timeout, elapsed
    );

    modport slave (
        input  en_wait_event, abort, wait_sel, mode, mask, value,
               occ_nb, max_timeout, wait_bank,
        output busy, wait_done, timeout, elapsed
    );
endinterface

// File: rtl/wait_event_mc.sv
// Multi-channel wait-event engine: watches one channel of a signal bank for
// rise/fall (with occurrence count), masked match or masked mismatch, with
// optional timeout and abort. All outputs are registered.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for a start request; outputs hold the last result
// ST_WAIT | sampling the selected channel once per clock edge
module wait_event_mc #(
    parameter int WAIT_SIZE  = 8,
    parameter int WAIT_WIDTH = 1,
    parameter int TIMEOUT_W  = 32,
    parameter int OCC_W      = 8,
    parameter int SEL_W      = (WAIT_SIZE > 1) ? $clog2(WAIT_SIZE) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    wait_event_mc_if.slave bus
);
    typedef enum logic {ST_IDLE, ST_WAIT} state_t;
    typedef enum logic [1:0] {
        MODE_RISE     = 2'b00,
        MODE_FALL     = 2'b01,
        MODE_MATCH    = 2'b10,
        MODE_MISMATCH = 2'b11
    } mode_t;

    state_t                state;
    mode_t                 mode_q;
    logic [SEL_W-1:0]      sel_q;
    logic [WAIT_WIDTH-1:0] mask_q;
    logic [WAIT_WIDTH-1:0] value_q;
    logic [OCC_W-1:0]      occ_q;
    logic [OCC_W-1:0]      edge_cnt;
    logic [TIMEOUT_W-1:0]  max_q;
    logic [TIMEOUT_W-1:0]  elapsed;
    logic                  base_valid;
    logic                  prev_lvl;
    logic                  busy;
    logic                  wait_done;
    logic                  timeout;

    logic [SEL_W-1:0]      sel_start;
    logic [WAIT_WIDTH-1:0] chan;
    logic [WAIT_WIDTH-1:0] s;
    logic                  lvl;
    logic                  edge_hit;
    logic                  hit;
    logic                  tmo_hit;
    logic [OCC_W-1:0]      edge_cnt_nxt;
    logic [TIMEOUT_W-1:0]  elapsed_nxt;

    // Out-of-range channel requests fall back to channel 0 at latch time.
    always_comb begin
        sel_start = (32'(bus.wait_sel) < 32'(WAIT_SIZE)) ? bus.wait_sel : '0;
    end

    // Select the latched channel out of the packed bank.
    always_comb begin
        chan = '0;
        for (int k = 0; k < WAIT_SIZE; k++) begin
            if (sel_q == SEL_W'(k)) chan = bus.wait_bank[k*WAIT_WIDTH +: WAIT_WIDTH];
        end
    end

    // Per-sample detection: masked level, edge against the previous sample,
    // level compare, saturating counters and timeout compare.
    always_comb begin
        s            = chan & mask_q;
        lvl          = |s;
        edge_cnt_nxt = (&edge_cnt) ? edge_cnt : edge_cnt + OCC_W'(1);
        elapsed_nxt  = (&elapsed) ? elapsed : elapsed + TIMEOUT_W'(1);
        edge_hit     = 1'b0;
        hit          = 1'b0;
        case (mode_q)
            MODE_RISE:     edge_hit = base_valid & ~prev_lvl & lvl;
            MODE_FALL:     edge_hit = base_valid & prev_lvl & ~lvl;
            MODE_MATCH:    hit = (s == (value_q & mask_q));
            MODE_MISMATCH: hit = (s != (value_q & mask_q));
            default:       hit = 1'b0;
        endcase
        if (edge_hit && (edge_cnt_nxt >= occ_q)) hit = 1'b1;
        tmo_hit = (max_q != '0) && (elapsed_nxt == max_q);
    end

    // Control FSM with registered busy/pulse/elapsed outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            mode_q     <= MODE_RISE;
            sel_q      <= '0;
            mask_q     <= '0;
            value_q    <= '0;
            occ_q      <= '0;
            max_q      <= '0;
            edge_cnt   <= '0;
            elapsed    <= '0;
            base_valid <= 1'b0;
            prev_lvl   <= 1'b0;
            busy       <= 1'b0;
            wait_done  <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            wait_done <= 1'b0;
            timeout   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // An abort on the same edge as a start drops the start.
                    if (bus.en_wait_event && !bus.abort) begin
                        mode_q     <= mode_t'(bus.mode);
                        sel_q      <= sel_start;
                        mask_q     <= bus.mask;
                        value_q    <= bus.value;
                        occ_q      <= (bus.occ_nb == '0) ? OCC_W'(1) : bus.occ_nb;
                        max_q      <= bus.max_timeout;
                        edge_cnt   <= '0;
                        elapsed    <= '0;
                        base_valid <= 1'b0;
                        prev_lvl   <= 1'b0;
                        busy       <= 1'b1;
                        state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // The aborting edge still counts as a sample taken.
                    elapsed    <= elapsed_nxt;
                    base_valid <= 1'b1;
                    prev_lvl   <= lvl;
                    if (edge_hit) edge_cnt <= edge_cnt_nxt;
                    if (bus.abort) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (hit) begin
                        wait_done <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end else if (tmo_hit) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy;
    assign bus.wait_done = wait_done;
    assign bus.timeout   = timeout;
    assign bus.elapsed   = elapsed;
endmodule
